// File: rtl/proj_trigger_shaper.sv
// Shapes each rising edge of the raw projector trigger into a fixed-width pulse with re-trigger holdoff,
// and keeps per-frame accepted/rejected trigger bookkeeping checked against the expected count at frame end.
module proj_trigger_shaper #(
    parameter int C_SYNC_STAGES = 2,
    parameter int C_MISS_W      = 16
) (
    input  logic                CLK_HS,
    input  logic                RESET,
    input  logic                TRIG_IN,
    input  logic                FRAME_END,
    input  logic [31:0]         PULSE_WIDTH,
    input  logic [31:0]         HOLDOFF,
    input  logic [31:0]         EXPECT_CNT,
    output logic                PROJ_TRIG,
    output logic                BUSY,
    output logic [31:0]         TRIG_CNT,
    output logic [31:0]         LAST_TRIG_CNT,
    output logic [C_MISS_W-1:0] MISS_CNT,
    output logic                FRAME_DONE,
    output logic                FRAME_ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_HOLDOFF
    } state_t;

    localparam logic [C_MISS_W-1:0] MISS_ONE = {{(C_MISS_W-1){1'b0}}, 1'b1};
    localparam logic [C_MISS_W-1:0] MISS_MAX = {C_MISS_W{1'b1}};

    state_t      state;
    state_t      state_nxt;
    logic [31:0] width_cnt;
    logic [31:0] width_cnt_nxt;
    logic [31:0] hold_cnt;
    logic [31:0] hold_cnt_nxt;
    logic [31:0] hold_lat;
    logic [31:0] hold_lat_nxt;
    logic        proj_nxt;
    logic        accept;
    logic        reject;

    logic        trig_q;
    logic        rise;

    logic [C_SYNC_STAGES-1:0] sync_chain;
    logic        sync_q;
    logic        fe;
    logic        frame_miss;

    assign rise = TRIG_IN & ~trig_q;
    assign fe   = sync_chain[C_SYNC_STAGES-1] & ~sync_q;
    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK_HS) begin
        if (RESET) begin
            state     <= S_IDLE;
            width_cnt <= 32'd0;
            hold_cnt  <= 32'd0;
            hold_lat  <= 32'd0;
            PROJ_TRIG <= 1'b0;
            trig_q    <= 1'b1;
        end else begin
            state     <= state_nxt;
            width_cnt <= width_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            hold_lat  <= hold_lat_nxt;
            PROJ_TRIG <= proj_nxt;
            trig_q    <= TRIG_IN;
        end
    end

    always_comb begin
        state_nxt     = state;
        width_cnt_nxt = width_cnt;
        hold_cnt_nxt  = hold_cnt;
        hold_lat_nxt  = hold_lat;
        proj_nxt      = PROJ_TRIG;
        accept        = 1'b0;
        reject        = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    accept        = 1'b1;
                    proj_nxt      = 1'b1;
                    width_cnt_nxt = (PULSE_WIDTH == 32'd0) ? 32'd0 : PULSE_WIDTH - 32'd1;
                    hold_lat_nxt  = HOLDOFF;
                    state_nxt     = S_PULSE;
                end
            end
            S_PULSE: begin
                reject = rise;
                if (width_cnt != 32'd0) begin
                    width_cnt_nxt = width_cnt - 32'd1;
                end else begin
                    proj_nxt = 1'b0;
                    if (hold_lat == 32'd0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        hold_cnt_nxt = hold_lat;
                        state_nxt    = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                reject       = rise;
                hold_cnt_nxt = hold_cnt - 32'd1;
                // <=1 rather than ==1 so a corrupted zero count cannot wrap into a 2^32 holdoff
                if (hold_cnt <= 32'd1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                proj_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_HS) begin
        if (RESET) begin
            sync_chain <= '0;
            sync_q     <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[C_SYNC_STAGES-2:0], FRAME_END};
            sync_q     <= sync_chain[C_SYNC_STAGES-1];
        end
    end

    // A trigger coinciding with frame end is booked against the new frame.
    always_ff @(posedge CLK_HS) begin
        if (RESET) begin
            TRIG_CNT      <= 32'd0;
            LAST_TRIG_CNT <= 32'd0;
            MISS_CNT      <= '0;
            FRAME_DONE    <= 1'b0;
            FRAME_ERR     <= 1'b0;
            frame_miss    <= 1'b0;
        end else begin
            FRAME_DONE <= fe;
            if (fe) begin
                LAST_TRIG_CNT <= TRIG_CNT;
                FRAME_ERR     <= (TRIG_CNT != EXPECT_CNT) | frame_miss;
                TRIG_CNT      <= accept ? 32'd1 : 32'd0;
            end else if (accept) begin
                TRIG_CNT <= TRIG_CNT + 32'd1;
            end
            if (reject) begin
                frame_miss <= 1'b1;
            end else if (fe) begin
                frame_miss <= 1'b0;
            end
            if (reject && (MISS_CNT != MISS_MAX)) begin
                MISS_CNT <= MISS_CNT + MISS_ONE;
            end
        end
    end

endmodule
